// File: rtl/hex_display_ctrl.sv
// Bus-attached 7-segment display controller: CPU-visible VALUE/CTRL/STATUS registers,
// round-robin sharing of one external hex decoder, blink and leading-zero blanking.
module hex_display_ctrl #(
  parameter int          NUM_DIGITS = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    mem_valid,
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic [3:0]              mem_wstrb,
  output logic                    mem_ready,
  output logic [31:0]             mem_rdata,
  output logic [3:0]              dec_in,
  input  logic [6:0]              dec_out,
  output logic [7*NUM_DIGITS-1:0] hex_segs
);

  localparam int          VW        = 4 * NUM_DIGITS;
  localparam int          CW        = $clog2(BLINK_DIV);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BLINK_DIV - 1);
  localparam logic [2:0]  SCAN_LAST = 3'(NUM_DIGITS - 1);

  logic                    sel_s;
  logic                    acc_s;
  logic                    wr_value_s;
  logic                    wr_ctrl_s;
  logic [31:0]             rd_mux_s;
  logic [3:0]              dec_s;
  logic [NUM_DIGITS-1:0]   lz_run_s;
  logic [NUM_DIGITS-1:0]   blank_s;
  logic                    wdata_unused_s;

  logic [VW-1:0]           value_q, value_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic [NUM_DIGITS-1:0]   blink_q, blink_d;
  logic                    lzb_q, lzb_d;
  logic [2:0]              scan_q, scan_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    phase_q, phase_d;
  logic                    ready_q, ready_d;
  logic [31:0]             rdata_q, rdata_d;
  logic [7*NUM_DIGITS-1:0] hex_q, hex_d;
  logic [6:0]              latch_q [NUM_DIGITS];

  assign sel_s          = mem_valid && (mem_addr[31:4] == BASE_ADDR[31:4]);
  assign acc_s          = sel_s && !ready_q;
  assign wr_value_s     = acc_s && (mem_wstrb != 4'b0000) && (mem_addr[3:0] == 4'h0);
  assign wr_ctrl_s      = acc_s && (mem_wstrb != 4'b0000) && (mem_addr[3:0] == 4'h4);
  assign wdata_unused_s = ^mem_wdata;

  // Read-data multiplexer over the register window
  always_comb begin
    rd_mux_s = 32'd0;
    case (mem_addr[3:0])
      4'h0:    rd_mux_s = 32'(value_q);
      4'h4:    rd_mux_s = 32'({lzb_q, 8'(blink_q), 8'(en_q)});
      4'h8:    rd_mux_s = {21'd0, scan_q, 7'd0, phase_q};
      default: rd_mux_s = 32'd0;
    endcase
  end

  // Bus handshake and byte-lane register writes, committed on the acknowledging edge
  always_comb begin
    ready_d = acc_s;
    if (acc_s && (mem_wstrb == 4'b0000)) begin
      rdata_d = rd_mux_s;
    end else begin
      rdata_d = 32'd0;
    end
    value_d = value_q;
    for (int j = 0; j < VW; j++) begin
      if (wr_value_s && mem_wstrb[j/8]) begin
        value_d[j] = mem_wdata[j];
      end else begin
        value_d[j] = value_q[j];
      end
    end
    if (wr_ctrl_s) begin
      en_d    = mem_wstrb[0] ? mem_wdata[NUM_DIGITS-1:0]   : en_q;
      blink_d = mem_wstrb[1] ? mem_wdata[8 +: NUM_DIGITS]  : blink_q;
      lzb_d   = mem_wstrb[2] ? mem_wdata[16]               : lzb_q;
    end else begin
      en_d    = en_q;
      blink_d = blink_q;
      lzb_d   = lzb_q;
    end
  end

  // Scan pointer, blink timebase and decoder nibble selection
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? 3'd0 : scan_q + 3'd1;
    if (wr_ctrl_s) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d   = cnt_q + CW'(1);
      phase_d = phase_q;
    end
    dec_s = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_q == 3'(i)) begin
        dec_s = value_q[4*i +: 4];
      end else begin
        dec_s = dec_s;
      end
    end
  end

  // Blanking: a digit is LZ-blanked when it and every more significant nibble are zero
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (value_q[4*i +: 4] == 4'd0);
      lz_run_s[i] = zero_run;
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      blank_s[i]       = ~en_q[i] | (blink_q[i] & phase_q) | (lzb_q & lz_run_s[i] & (i != 0));
      hex_d[7*i +: 7]  = blank_s[i] ? 7'h7F : latch_q[i];
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      value_q <= '0;
      en_q    <= '1;
      blink_q <= '0;
      lzb_q   <= 1'b0;
      scan_q  <= 3'd0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      ready_q <= 1'b0;
      rdata_q <= 32'd0;
      hex_q   <= '1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        latch_q[i] <= 7'h7F;
      end
    end else begin
      value_q <= value_d;
      en_q    <= en_d;
      blink_q <= blink_d;
      lzb_q   <= lzb_d;
      scan_q  <= scan_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (scan_q == 3'(i)) begin
          latch_q[i] <= dec_out;
        end
      end
    end
  end

  assign mem_ready = ready_q;
  assign mem_rdata = rdata_q;
  assign dec_in    = dec_s;
  assign hex_segs  = hex_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl: external decoder model, abstract display model
// checked every cycle, plus literal expectations from hand-decoded segment patterns.
module tb_hex_display_ctrl;

  localparam int          N    = 4;
  localparam int          DIV  = 4;
  localparam logic [31:0] BASE = 32'h1000_0000;

  logic          clk = 1'b0;
  logic          resetn;
  logic          mem_valid;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [31:0]   mem_rdata;
  logic [3:0]    dec_in;
  logic [6:0]    dec_out;
  logic [7*N-1:0] hex_segs;

  int n_vec = 0;
  int n_err = 0;
  int req_id = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  assign dec_out = seg7(dec_in);

  hex_display_ctrl #(.NUM_DIGITS(N), .BASE_ADDR(BASE), .BLINK_DIV(DIV)) dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .dec_in(dec_in), .dec_out(dec_out), .hex_segs(hex_segs)
  );

  // Abstract model: cycle count gives the scan slot, edges since the last CTRL write give the phase
  logic [15:0]  val_m;
  logic [N-1:0] en_m, bl_m;
  logic         lz_m;
  int           cyc_m, k_m, seen_id;
  logic [6:0]   lat_m [N];
  logic [7*N-1:0] hex_m;

  function automatic bit phase_m();
    return ((k_m / DIV) % 2) == 1;
  endfunction

  function automatic bit blank_m(input int i);
    return !en_m[i] || (bl_m[i] && phase_m()) || (lz_m && i != 0 && (val_m >> (4*i)) == 16'd0);
  endfunction

  function automatic logic [31:0] model_rdata(input logic [3:0] off);
    case (off)
      4'h0:    return 32'(val_m);
      4'h4:    return 32'({lz_m, 4'b0000, bl_m, 4'b0000, en_m});
      4'h8:    return {21'd0, 3'(cyc_m % N), 7'd0, phase_m()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      val_m <= 16'd0; en_m <= '1; bl_m <= '0; lz_m <= 1'b0;
      cyc_m <= 0; k_m <= 0; seen_id <= req_id; hex_m <= '1;
      for (int i = 0; i < N; i++) lat_m[i] <= 7'h7F;
    end else begin
      for (int i = 0; i < N; i++) hex_m[7*i +: 7] <= blank_m(i) ? 7'h7F : lat_m[i];
      lat_m[cyc_m % N] <= seg7(val_m[4*(cyc_m % N) +: 4]);
      cyc_m <= cyc_m + 1;
      k_m   <= k_m + 1;
      if (req_id != seen_id) begin
        seen_id <= req_id;
        if (mem_valid && mem_addr[31:4] == BASE[31:4] && mem_wstrb != 4'b0000) begin
          if (mem_addr[3:0] == 4'h0) begin
            val_m <= {mem_wstrb[1] ? mem_wdata[15:8] : val_m[15:8],
                      mem_wstrb[0] ? mem_wdata[7:0]  : val_m[7:0]};
          end else if (mem_addr[3:0] == 4'h4) begin
            en_m <= mem_wstrb[0] ? mem_wdata[N-1:0]  : en_m;
            bl_m <= mem_wstrb[1] ? mem_wdata[8 +: N] : bl_m;
            lz_m <= mem_wstrb[2] ? mem_wdata[16]     : lz_m;
            k_m  <= 0;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                     input bit ack, input string name, output logic [31:0] rd);
    logic [31:0] exp;
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = strb;
    req_id++;
    exp = model_rdata(addr[3:0]);
    check({name, " ready_before"}, 32'(mem_ready), 32'd0);
    rd = 32'd0;
    if (ack) begin
      @(posedge clk); #1;
      check({name, " ack"}, 32'(mem_ready), 32'd1);
      rd = mem_rdata;
      if (strb == 4'b0000) check({name, " rdata"}, mem_rdata, exp);
      @(negedge clk);
      mem_valid = 1'b0; mem_wstrb = 4'b0000;
      @(posedge clk); #1;
      check({name, " ack_one_cycle"}, 32'(mem_ready), 32'd0);
    end else begin
      repeat (3) begin
        @(posedge clk); #1;
        check({name, " no_ack"}, 32'(mem_ready), 32'd0);
      end
      @(negedge clk);
      mem_valid = 1'b0; mem_wstrb = 4'b0000;
    end
  endtask

  initial begin
    logic [31:0] rd;
    resetn = 1'b0; mem_valid = 1'b0; mem_addr = 32'd0; mem_wdata = 32'd0; mem_wstrb = 4'b0000;
    repeat (2) @(negedge clk);
    check("reset_segs", 32'(hex_segs), 32'h0FFF_FFFF);
    check("reset_ready", 32'(mem_ready), 32'd0);
    check("reset_rdata", mem_rdata, 32'd0);
    fork
      forever begin
        @(negedge clk);
        check("cycle_segs", 32'(hex_segs), 32'(hex_m));
        check("cycle_dec_in", 32'(dec_in), 32'(val_m[4*(cyc_m % N) +: 4]));
      end
    join_none
    resetn = 1'b1;
    repeat (N + 1) @(posedge clk); #1;
    check("zeros_after_refresh", 32'(hex_segs), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

    bus(BASE + 32'h0, 32'h0000_1A3F, 4'hF, 1'b1, "wr_value", rd);
    repeat (6) @(posedge clk); #1;
    check("value_1a3f", 32'(hex_segs), 32'({7'h79, 7'h08, 7'h30, 7'h0E}));
    bus(BASE + 32'h0, 32'd0, 4'h0, 1'b1, "rd_value", rd);
    check("rd_value_lit", rd, 32'h0000_1A3F);

    bus(BASE + 32'h4, 32'h0001_000F, 4'hF, 1'b1, "wr_ctrl_lzb", rd);
    bus(BASE + 32'h0, 32'h0000_0005, 4'hF, 1'b1, "wr_value5", rd);
    repeat (6) @(posedge clk); #1;
    check("lzb_value5", 32'(hex_segs), 32'({7'h7F, 7'h7F, 7'h7F, 7'h12}));
    bus(BASE + 32'h0, 32'h0000_0000, 4'hF, 1'b1, "wr_value0", rd);
    repeat (6) @(posedge clk); #1;
    check("lzb_digit0_kept", 32'(hex_segs), 32'({7'h7F, 7'h7F, 7'h7F, 7'h40}));

    bus(BASE + 32'h0, 32'h0000_1A3F, 4'hF, 1'b1, "wr_value_blink", rd);
    repeat (6) @(posedge clk);
    bus(BASE + 32'h4, 32'h0000_020F, 4'hF, 1'b1, "wr_ctrl_blink", rd);
    check("blink_visible", 32'(hex_segs[13:7]), 32'(7'h30));
    repeat (4) @(posedge clk); #1;
    check("blink_blanked", 32'(hex_segs[13:7]), 32'(7'h7F));
    bus(BASE + 32'h4, 32'h0000_020F, 4'hF, 1'b1, "rewrite_ctrl", rd);
    check("rewrite_visible", 32'(hex_segs[13:7]), 32'(7'h30));
    bus(BASE + 32'h8, 32'd0, 4'h0, 1'b1, "rd_status", rd);
    check("status_phase0", 32'(rd[0]), 32'd0);
    repeat (12) @(posedge clk);

    bus(BASE + 32'h0, 32'h0000_1234, 4'hF, 1'b1, "wr_value1234", rd);
    bus(BASE + 32'h0, 32'hFFFF_FFFF, 4'b0001, 1'b1, "wr_lane0", rd);
    bus(BASE + 32'h0, 32'd0, 4'h0, 1'b1, "rd_lane0", rd);
    check("lane0_lit", rd, 32'h0000_12FF);
    bus(BASE + 32'hC, 32'hDEAD_BEEF, 4'hF, 1'b1, "wr_offc", rd);
    bus(BASE + 32'hC, 32'd0, 4'h0, 1'b1, "rd_offc", rd);
    check("offc_lit", rd, 32'd0);
    bus(32'h2000_0000, 32'h0000_5555, 4'hF, 1'b0, "outside", rd);
    bus(BASE + 32'h0, 32'd0, 4'h0, 1'b1, "rd_after_outside", rd);
    check("outside_lit", rd, 32'h0000_12FF);
    repeat (6) @(posedge clk);

    @(negedge clk);
    mem_valid = 1'b1; mem_addr = BASE; mem_wstrb = 4'b0000; req_id++;
    @(posedge clk); #1;
    check("midreset_ack", 32'(mem_ready), 32'd1);
    resetn = 1'b0;
    #1;
    check("midreset_ready", 32'(mem_ready), 32'd0);
    check("midreset_rdata", mem_rdata, 32'd0);
    check("midreset_segs", 32'(hex_segs), 32'h0FFF_FFFF);
    @(negedge clk);
    mem_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (N + 1) @(posedge clk); #1;
    check("post_reset_zeros", 32'(hex_segs), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
